// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle subtractor, RSub = DataA - DataB, CHUNK bits per clock
// Ports: Clock (rising edge), ResetN (async, active-low), Start (request),
//   DataA/DataB (operands, latched on the accepting edge), Busy (RUN), Done (1-cycle pulse),
//   RSub (difference mod 2^WIDTH), BorrowOut (DataA < DataB unsigned), Zero (RSub == 0).
// Optional: define SERIAL_SUBTRACTOR_OVERFLOW_EN to add Overflow (signed two's-complement overflow).
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] RSub,
    output logic             BorrowOut,
    output logic             Zero
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("serial_subtractor: WIDTH must be an integer multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_q, b_q, rsub_nx;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] d;
    logic             borrow, b_out, accept, last;

    // Start is honoured in IDLE and DONE (back-to-back), ignored in RUN
    assign accept = Start && state != RUN;
    assign last   = state == RUN && idx == LAST;
    assign Busy   = state == RUN;
    assign Done   = state == DONE;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = accept ? RUN : last ? DONE : Busy ? RUN : IDLE;
    end

    // One chunk of the difference; the extra top bit of the CHUNK+1 result is the borrow out
    always_comb begin
        {b_out, d} = {1'b0, a_q[idx*CHUNK +: CHUNK]} - {1'b0, b_q[idx*CHUNK +: CHUNK]}
                     - {{CHUNK{1'b0}}, borrow};
        rsub_nx = RSub;
        rsub_nx[idx*CHUNK +: CHUNK] = d;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            borrow    <= 1'b0;
            RSub      <= '0;
            BorrowOut <= 1'b0;
            Zero      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            Overflow  <= 1'b0;
`endif
        end else if (accept) begin
            a_q       <= DataA;
            b_q       <= DataB;
            idx       <= '0;
            borrow    <= 1'b0;
            BorrowOut <= 1'b0;
            Zero      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            Overflow  <= 1'b0;
`endif
        end else if (Busy) begin
            RSub   <= rsub_nx;
            borrow <= b_out;
            idx    <= last ? '0 : idx + IW'(1);
            if (last) begin
                BorrowOut <= b_out;
                Zero      <= rsub_nx == '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                Overflow  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (rsub_nx[WIDTH-1] != a_q[WIDTH-1]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor (default 32/8 build)
module tb_serial_subtractor;
    logic        Clock = 1'b0;
    logic        ResetN, Start;
    logic [31:0] DataA, DataB;
    logic        Busy, Done, BorrowOut, Zero;
    logic [31:0] RSub;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic        Overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_subtractor dut (
        .Clock     (Clock),
        .ResetN    (ResetN),
        .Start     (Start),
        .DataA     (DataA),
        .DataB     (DataB),
        .Busy      (Busy),
        .Done      (Done),
        .RSub      (RSub),
        .BorrowOut (BorrowOut),
        .Zero      (Zero)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        ,
        .Overflow  (Overflow)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ends at the negedge after the accepting edge, with Start low again
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge Clock);
        Start = 1'b1;
        DataA = a;
        DataB = b;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    // mode 0: quiet, 1: scramble operands each RUN cycle, 2: hold Start high during RUN
    task automatic wait_done(input int mode, output int busy_n);
        int cyc;
        busy_n = 0;
        cyc    = 0;
        while (!Done && cyc < 20) begin
            if (Busy) busy_n++;
            if (mode == 1) begin
                DataA = $urandom;
                DataB = $urandom;
            end
            if (mode == 2) Start = 1'b1;
            @(negedge Clock);
            cyc++;
        end
        Start = 1'b0;
    endtask

    task automatic check_op(input string tag, input int busy_n, input logic [31:0] r,
                            input logic bo, input logic z);
        chk({tag, "_busy"}, busy_n, 4);
        chk({tag, "_done"}, {31'b0, Done}, 1);
        chk({tag, "_rsub"}, RSub, r);
        chk({tag, "_borrow"}, {31'b0, BorrowOut}, {31'b0, bo});
        chk({tag, "_zero"}, {31'b0, Zero}, {31'b0, z});
    endtask

    initial begin
        int bn, n, extra;
        ResetN = 1'b0;
        Start  = 1'b0;
        DataA  = '0;
        DataB  = '0;
        repeat (2) @(negedge Clock);
        chk("rst_busy", {31'b0, Busy}, 0);
        chk("rst_done", {31'b0, Done}, 0);
        chk("rst_rsub", RSub, 0);
        chk("rst_borrow", {31'b0, BorrowOut}, 0);
        chk("rst_zero", {31'b0, Zero}, 0);
        ResetN = 1'b1;

        start_op(32'h0000_0005, 32'h0000_0003);
        wait_done(0, bn);
        check_op("basic", bn, 32'h0000_0002, 1'b0, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk("basic_ovf", {31'b0, Overflow}, 0);
`endif
        @(negedge Clock);
        chk("basic_done_pulse", {31'b0, Done}, 0);
        chk("basic_hold", RSub, 32'h0000_0002);

        start_op(32'h0000_0000, 32'h0000_0001);
        wait_done(0, bn);
        check_op("chain", bn, 32'hFFFF_FFFF, 1'b1, 1'b0);

        start_op(32'hDEAD_BEEF, 32'hDEAD_BEEF);
        wait_done(0, bn);
        check_op("equal", bn, 32'h0000_0000, 1'b0, 1'b1);

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        start_op(32'h8000_0000, 32'h0000_0001);
        wait_done(0, bn);
        check_op("ovf", bn, 32'h7FFF_FFFF, 1'b0, 1'b0);
        chk("ovf_flag", {31'b0, Overflow}, 1);
`endif

        // Start held high throughout RUN must not restart or extend the operation
        start_op(32'h0000_0020, 32'h0000_0008);
        wait_done(2, bn);
        check_op("spam", bn, 32'h0000_0018, 1'b0, 1'b0);
        extra = 0;
        repeat (6) begin
            @(negedge Clock);
            if (Done || Busy) extra++;
        end
        chk("spam_single_done", extra, 0);

        // Back-to-back: a new Start during the DONE cycle
        start_op(32'h0000_0003, 32'h0000_0003);
        wait_done(0, bn);
        check_op("b2b_first", bn, 32'h0000_0000, 1'b0, 1'b1);
        Start = 1'b1;
        DataA = 32'd10;
        DataB = 32'd4;
        @(negedge Clock);
        Start = 1'b0;
        n = 1;
        chk("b2b_zero_cleared", {31'b0, Zero}, 0);
        chk("b2b_busy", {31'b0, Busy}, 1);
        while (!Done && n < 20) begin
            @(negedge Clock);
            n++;
        end
        chk("b2b_latency", n, 5);
        chk("b2b_rsub", RSub, 32'd6);

        // Reset during the second RUN cycle (chunk 0 already written)
        start_op(32'h1234_5678, 32'h0000_0001);
        @(negedge Clock);
        ResetN = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, Busy}, 0);
        chk("mid_rst_done", {31'b0, Done}, 0);
        chk("mid_rst_rsub", RSub, 0);
        chk("mid_rst_borrow", {31'b0, BorrowOut}, 0);
        chk("mid_rst_zero", {31'b0, Zero}, 0);
        extra = 0;
        repeat (3) begin
            @(negedge Clock);
            if (Done) extra++;
        end
        chk("mid_rst_no_done", extra, 0);
        ResetN = 1'b1;
        start_op(32'h0000_0001, 32'h0000_0001);
        wait_done(0, bn);
        check_op("after_rst", bn, 32'h0000_0000, 1'b0, 1'b1);

        // Operand inputs wiggle during RUN; latched values must be used
        start_op(32'h0000_0100, 32'h0000_0001);
        wait_done(1, bn);
        check_op("hold", bn, 32'h0000_00FF, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
